// File: rtl/fetch_redirect_unit.sv
// In-order fetch front end that redirects on execute's branch/jump target and buffers returned words with PCs.
// Optional macro FETCH_MISALIGN_CHECK_EN: a misaligned redirect target sets sticky misalign_o and halts fetch.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0100_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_target_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        insn_valid_o,
  input  logic        insn_ready_i,
  output logic [31:0] insn_o,
  output logic [31:0] insn_pc_o,
  output logic        misalign_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   pc_q, pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [31:0]   insn_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [CW:0]   used;
  logic          halted, req_fire, rsp, droppable, push, pop;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic halted_q, halted_d;
  assign halted = halted_q;
  assign halted_d = halted_q | (redirect_valid_i & (redirect_target_i[1:0] != 2'b00));
  assign misalign_o = halted_q & ~reset;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) halted_q <= 1'b0;
    else       halted_q <= halted_d;
  end
`else
  assign halted = 1'b0;
  assign misalign_o = 1'b0;
`endif

  // Credits count both in-flight requests and buffered words, so a response always has a slot.
  assign used             = {1'b0, out_q} + {1'b0, cnt_q};
  assign imem_req_valid_o = ~reset & ~redirect_valid_i & (used < DEPTH_W) & ~halted;
  assign imem_req_addr_o  = pc_q;
  assign req_fire         = imem_req_valid_o & imem_req_ready_i;
  assign rsp              = imem_rsp_valid_i;
  assign droppable        = (drop_q != '0);
  assign push             = rsp & ~droppable & ~redirect_valid_i & ~reset;

  assign insn_valid_o = ~reset & (cnt_q != '0) & ~redirect_valid_i;
  assign pop          = insn_valid_o & insn_ready_i;
  assign insn_o       = reset ? 32'h0 : insn_mem[rd_q];
  assign insn_pc_o    = reset ? 32'h0 : pc_mem[rd_q];

  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    drop_d   = drop_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    out_d    = out_q + CW'(req_fire) - CW'(rsp);
    if (redirect_valid_i) begin
      pc_d     = redirect_target_i;
      rsp_pc_d = redirect_target_i;
      cnt_d    = '0;
      wr_d     = '0;
      rd_d     = '0;
      // Every request still in flight after this cycle belongs to the abandoned path.
      drop_d   = out_q - CW'(rsp);
    end else begin
      if (req_fire)        pc_d     = pc_q + 32'd4;
      if (rsp && droppable) drop_d  = drop_q - CW'(1);
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_d     = wr_q + AW'(1);
      end
      if (pop)             rd_d     = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      cnt_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      insn_mem[wr_q] <= imem_rsp_data_i;
      pc_mem[wr_q]   <= rsp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Randomized bench for fetch_redirect_unit: queue-based memory and fetch-stream reference model.
module tb_fetch_redirect_unit;
  localparam logic [31:0] RESET_PC = 32'h0100_0000;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic redirect_valid_i = 1'b0;
  logic [31:0] redirect_target_i = '0;
  logic imem_req_valid_o, imem_req_ready_i = 1'b0;
  logic [31:0] imem_req_addr_o;
  logic imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = '0;
  logic insn_valid_o, insn_ready_i = 1'b0;
  logic [31:0] insn_o, insn_pc_o;
  logic misalign_o;

  always #5 clk = ~clk;

  fetch_redirect_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid_i(redirect_valid_i), .redirect_target_i(redirect_target_i),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o(imem_req_addr_o),
    .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_data_i(imem_rsp_data_i),
    .insn_valid_o(insn_valid_o), .insn_ready_i(insn_ready_i),
    .insn_o(insn_o), .insn_pc_o(insn_pc_o), .misalign_o(misalign_o)
  );

  typedef struct { logic [31:0] addr; bit dead; int rdy; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  pend_t pend[$];       // requests accepted by memory, oldest first
  ent_t  bufm[$];       // words decode should see next, oldest first
  ent_t  pop_log[$];
  logic [31:0] req_log[$];
  logic [31:0] req_pc;
  bit halted = 0;
  bit last_ins_vld;
  int p_redir, p_rdy, p_dec, p_rsp, lat_max;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic void reset_model();
    pend.delete(); bufm.delete(); pop_log.delete(); req_log.delete();
    req_pc = RESET_PC; halted = 0;
  endfunction

  task automatic set_knobs(input int r, input int q, input int d, input int s, input int l);
    p_redir = r; p_rdy = q; p_dec = d; p_rsp = s; lat_max = l;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid_i = 1'b0; imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0; insn_ready_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    reset_model();
  endtask

  // One clock: drive inputs just after posedge, compare at negedge, then advance the model.
  task automatic cycle_step(input bit force_redir, input logic [31:0] force_tgt);
    bit rsp, redir, exp_req, exp_ins;
    pend_t p;
    ent_t e;
    redir = force_redir || ($urandom_range(99) < p_redir);
    redirect_valid_i  = redir;
    redirect_target_i = force_redir ? force_tgt : RESET_PC + ($urandom_range(0, 255) << 2);
    imem_req_ready_i  = ($urandom_range(99) < p_rdy);
    insn_ready_i      = ($urandom_range(99) < p_dec);
    rsp = (pend.size() > 0) && (pend[0].rdy <= cyc) && ($urandom_range(99) < p_rsp);
    imem_rsp_valid_i  = rsp;
    imem_rsp_data_i   = rsp ? memf(pend[0].addr) : $urandom;
    @(negedge clk);
    exp_req = !redir && (pend.size() + bufm.size() < DEPTH) && !halted;
    exp_ins = !redir && (bufm.size() > 0);
    last_ins_vld = insn_valid_o;
    checks++;
    if (imem_req_valid_o !== exp_req) begin
      errors++; $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid_o, exp_req);
    end
    if (exp_req) begin
      checks++;
      if (imem_req_addr_o !== req_pc) begin
        errors++; $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr_o, req_pc);
      end
    end
    checks++;
    if (insn_valid_o !== exp_ins) begin
      errors++; $display("FAIL insn_valid cyc=%0d got=%b exp=%b", cyc, insn_valid_o, exp_ins);
    end
    if (exp_ins) begin
      checks++;
      if (insn_pc_o !== bufm[0].pc || insn_o !== bufm[0].data) begin
        errors++;
        $display("FAIL insn cyc=%0d got pc=%h data=%h exp pc=%h data=%h",
                 cyc, insn_pc_o, insn_o, bufm[0].pc, bufm[0].data);
      end
    end
    checks++;
    if (misalign_o !== halted) begin
      errors++; $display("FAIL misalign cyc=%0d got=%b exp=%b", cyc, misalign_o, halted);
    end
    if (redir) begin
      foreach (pend[i]) pend[i].dead = 1;
      if (rsp) void'(pend.pop_front());
      bufm.delete();
      req_pc = redirect_target_i;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (redirect_target_i[1:0] != 2'b00) halted = 1;
`endif
    end else begin
      if (exp_ins && insn_ready_i) begin
        pop_log.push_back(bufm[0]);
        void'(bufm.pop_front());
      end
      if (rsp) begin
        p = pend.pop_front();
        if (!p.dead) begin
          e.pc = p.addr; e.data = memf(p.addr);
          bufm.push_back(e);
        end
      end
      if (exp_req && imem_req_ready_i) begin
        p.addr = req_pc; p.dead = 0; p.rdy = cyc + $urandom_range(1, lat_max);
        pend.push_back(p);
        req_log.push_back(req_pc);
        req_pc = req_pc + 32'd4;
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle_step(1'b0, 32'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    redirect_valid_i = 1'b1; redirect_target_i = 32'h0200_0000;
    imem_req_ready_i = 1'b1; imem_rsp_valid_i = 1'b1; insn_ready_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({imem_req_valid_o, insn_valid_o, misalign_o} !== 3'b000 || insn_o !== 32'h0 || insn_pc_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got req=%b ins=%b mis=%b insn=%h pc=%h exp all zero",
               imem_req_valid_o, insn_valid_o, misalign_o, insn_o, insn_pc_o);
    end
    do_reset();
    set_knobs(0, 100, 100, 100, 1);
    run(1);
    checks++;
    if (req_log.size() < 1 || req_log[0] !== RESET_PC) begin
      errors++; $display("FAIL reset_first_req got n=%0d exp first=%h", req_log.size(), RESET_PC);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    set_knobs(0, 100, 100, 100, 1);
    run(14);
    checks++;
    if (req_log.size() < 3 || pop_log.size() < 3) begin
      errors++; $display("FAIL seq_count got req=%0d pop=%0d exp >=3 each", req_log.size(), pop_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (req_log[i] !== RESET_PC + 32'(4 * i) || pop_log[i].pc !== RESET_PC + 32'(4 * i) ||
            pop_log[i].data !== memf(RESET_PC + 32'(4 * i))) begin
          errors++;
          $display("FAIL seq_%0d got req=%h pc=%h data=%h exp pc=%h", i, req_log[i],
                   pop_log[i].pc, pop_log[i].data, RESET_PC + 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_knobs(0, 100, 0, 100, 1);
    run(10);
    checks++;
    if (req_log.size() != DEPTH || imem_req_valid_o !== 1'b0) begin
      errors++; $display("FAIL bp_stall got reqs=%0d valid=%b exp reqs=%0d valid=0",
                         req_log.size(), imem_req_valid_o, DEPTH);
    end
    set_knobs(0, 100, 100, 100, 1);
    run(20);
    checks++;
    if (req_log.size() > pop_log.size() + DEPTH || pop_log.size() < 4) begin
      errors++; $display("FAIL bp_resume got reqs=%0d pops=%0d exp reqs<=pops+%0d pops>=4",
                         req_log.size(), pop_log.size(), DEPTH);
    end
    for (int i = 0; i < pop_log.size(); i++) begin
      checks++;
      if (pop_log[i].pc !== RESET_PC + 32'(4 * i)) begin
        errors++; $display("FAIL bp_order_%0d got=%h exp=%h", i, pop_log[i].pc, RESET_PC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect_drop();
    do_reset();
    set_knobs(0, 100, 0, 0, 1);
    run(3);
    cycle_step(1'b1, 32'h0100_0040);
    set_knobs(0, 100, 100, 100, 1);
    run(10);
    checks++;
    if (pop_log.size() < 1 || pop_log[0].pc !== 32'h0100_0040 || pop_log[0].data !== memf(32'h0100_0040)) begin
      errors++; $display("FAIL redirect_drop got n=%0d pc=%h exp pc=%h",
                         pop_log.size(), pop_log.size() ? pop_log[0].pc : 32'h0, 32'h0100_0040);
    end
  endtask

  task automatic test_redirect_collision();
    int npop, nreq;
    do_reset();
    set_knobs(0, 100, 100, 100, 1);
    run(2);
    npop = pop_log.size();
    cycle_step(1'b1, 32'h0100_0100);
    checks++;
    if (last_ins_vld !== 1'b0 || pop_log.size() != npop) begin
      errors++; $display("FAIL collide_valid got valid=%b pops=%0d exp valid=0 pops=%0d",
                         last_ins_vld, pop_log.size(), npop);
    end
    nreq = req_log.size();
    run(8);
    checks++;
    if (req_log.size() <= nreq || req_log[nreq] !== 32'h0100_0100) begin
      errors++; $display("FAIL collide_req got n=%0d exp next req=%h", req_log.size(), 32'h0100_0100);
    end
    checks++;
    if (pop_log.size() <= npop || pop_log[npop].pc !== 32'h0100_0100) begin
      errors++; $display("FAIL collide_insn got n=%0d exp pc=%h", pop_log.size(), 32'h0100_0100);
    end
  endtask

  task automatic test_wrap();
    int n0;
    logic [31:0] exp_a [3];
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0000_0000;
    set_knobs(0, 100, 100, 100, 1);
    n0 = req_log.size();
    cycle_step(1'b1, 32'hFFFF_FFF8);
    run(12);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (req_log.size() <= n0 + i || req_log[n0 + i] !== exp_a[i]) begin
        errors++; $display("FAIL wrap_%0d got n=%0d exp=%h", i, req_log.size(), exp_a[i]);
      end
    end
  endtask

  task automatic test_misalign();
    int n0;
    set_knobs(0, 100, 100, 100, 2);
`ifdef FETCH_MISALIGN_CHECK_EN
    cycle_step(1'b1, 32'h0100_0002);
    n0 = req_log.size();
    run(20);
    checks++;
    if (misalign_o !== 1'b1 || imem_req_valid_o !== 1'b0 || req_log.size() != n0) begin
      errors++; $display("FAIL misalign_halt got mis=%b valid=%b reqs=%0d exp mis=1 valid=0 reqs=%0d",
                         misalign_o, imem_req_valid_o, req_log.size(), n0);
    end
`else
    n0 = req_log.size();
    cycle_step(1'b1, 32'h0100_0042);
    run(6);
    checks++;
    if (req_log.size() <= n0 || req_log[n0] !== 32'h0100_0042 || misalign_o !== 1'b0) begin
      errors++; $display("FAIL misalign_pass got n=%0d mis=%b exp req=%h mis=0",
                         req_log.size(), misalign_o, 32'h0100_0042);
    end
`endif
  endtask

  task automatic test_mid_reset();
    set_knobs(0, 80, 50, 80, 3);
    run(15);
    reset = 1'b1;
    #1;
    checks++;
    if ({imem_req_valid_o, insn_valid_o, misalign_o} !== 3'b000 || insn_o !== 32'h0 || insn_pc_o !== 32'h0) begin
      errors++;
      $display("FAIL midreset_outputs got req=%b ins=%b mis=%b insn=%h pc=%h exp all zero",
               imem_req_valid_o, insn_valid_o, misalign_o, insn_o, insn_pc_o);
    end
    do_reset();
    set_knobs(0, 100, 100, 100, 1);
    run(6);
    checks++;
    if (req_log.size() < 1 || req_log[0] !== RESET_PC || pop_log.size() < 1 || pop_log[0].pc !== RESET_PC) begin
      errors++; $display("FAIL midreset_restart got reqs=%0d pops=%0d exp restart at %h",
                         req_log.size(), pop_log.size(), RESET_PC);
    end
  endtask

  task automatic test_random();
    do_reset();
    set_knobs(5, 70, 60, 70, 4);
    run(3000);
    checks++;
    if (pop_log.size() < 100) begin
      errors++; $display("FAIL random_progress got pops=%0d exp >=100", pop_log.size());
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_drop();
    test_redirect_collision();
    test_wrap();
    test_misalign();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
